ecall_responder: RTL and testbench

- Consumes the EX-stage ecall flag and services the environment call on behalf of the core.
- On an asserted flag it freezes the pipeline, latches the service code (a7) and argument (a0), and performs the service:
  - print a0 as 8 hex ASCII characters,
  - print one character,
  - halt, or
  - ignore an unknown code.
- Characters go to a byte sink over a valid/ready handshake.
- Sits between the EX ecall pipeline register output, the hazard/stall logic and the character output device (UART/display buffer).

---
 rtl/ecall_pkg.sv | 23 ++
 rtl/ecall_responder_hex_ascii_nibble.sv | 13 +
 rtl/ecall_responder.sv | 156 +++++++++++++++
 tb/tb_ecall_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecall_pkg.sv
// Shared definitions for the ecall responder: FSM state encoding, default
// service codes and the ASCII constants used to render hex digits.
package ecall_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND   = 3'd1,
        NL     = 3'd2,
        DONE   = 3'd3,
        HALTED = 3'd4
    } ecall_state_t;

    localparam logic [31:0] SVC_PRINT_INT_DEF  = 32'd1;
    localparam logic [31:0] SVC_EXIT_DEF       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR_DEF = 32'd11;

    localparam logic [7:0] ASCII_ZERO       = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_BIAS = 8'h37;
    localparam logic [7:0] ASCII_LF         = 8'h0A;

    localparam logic [2:0] LAST_HEX_IDX = 3'd7;

endpackage

// File: rtl/ecall_responder_hex_ascii_nibble.sv
// Combinational 4-bit to uppercase hex ASCII converter, shared with the
// display path.
module hex_ascii_nibble
    import ecall_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = (nibble < 4'd10) ? (ASCII_ZERO + {4'h0, nibble})
                                    : (ASCII_ALPHA_BIAS + {4'h0, nibble});

endmodule

// File: rtl/ecall_responder.sv
// Services EX-stage environment calls: print hex, print char, halt, or count
// unknown codes. Build with ECALL_NEWLINE_EN to append a newline to hex prints.
module ecall_responder
    import ecall_pkg::*;
#(
    parameter logic [31:0] SVC_PRINT_INT  = SVC_PRINT_INT_DEF,
    parameter logic [31:0] SVC_EXIT       = SVC_EXIT_DEF,
    parameter logic [31:0] SVC_PRINT_CHAR = SVC_PRINT_CHAR_DEF,
    parameter int          CNT_BITS       = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                ecall,
    input  logic [31:0]         a7,
    input  logic [31:0]         a0,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [7:0]          out_data,
    output logic                Stall,
    output logic                Halt,
    output logic                ecall_done,
    output logic [CNT_BITS-1:0] unknown_cnt,
    output logic [2:0]          dbg_state
);

    // Sink handshake: a byte moves on a rising edge where out_valid,
    // out_ready and ClockEnable are all 1; out_valid and out_data hold until then.

    ecall_state_t        state_q, state_d;
    logic [31:0]         code_q, code_d;
    logic [31:0]         arg_q, arg_d;
    logic [2:0]          idx_q, idx_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                halt_entry_q, halt_entry_d;

    logic                stall_c;
    logic                is_char;
    logic                last_byte;
    logic [3:0]          nibble;
    logic [7:0]          hex_char;

    assign is_char   = (code_q == SVC_PRINT_CHAR);
    assign last_byte = is_char || (idx_q == LAST_HEX_IDX);
    // Most significant nibble first: idx 0 selects arg[31:28].
    assign nibble    = arg_q[(5'd28 - {idx_q, 2'b00}) +: 4];

    hex_ascii_nibble u_hex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        arg_d        = arg_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        halt_entry_d = 1'b0;
        stall_c      = 1'b0;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        Halt         = 1'b0;
        ecall_done   = 1'b0;

        case (state_q)
            IDLE: begin
                stall_c = ecall;
                if (ecall) begin
                    code_d = a7;
                    arg_d  = a0;
                    idx_d  = 3'd0;
                    if (a7 == SVC_PRINT_INT || a7 == SVC_PRINT_CHAR) begin
                        state_d = SEND;
                    end else if (a7 == SVC_EXIT) begin
                        state_d      = HALTED;
                        halt_entry_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end

            SEND: begin
                stall_c   = 1'b1;
                out_valid = 1'b1;
                out_data  = is_char ? arg_q[7:0] : hex_char;
                if (out_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (last_byte) begin
`ifdef ECALL_NEWLINE_EN
                        state_d = is_char ? DONE : NL;
`else
                        state_d = DONE;
`endif
                    end
                end
            end

`ifdef ECALL_NEWLINE_EN
            NL: begin
                stall_c   = 1'b1;
                out_valid = 1'b1;
                out_data  = ASCII_LF;
                if (out_ready) begin
                    state_d = DONE;
                end
            end
`endif

            // One unstalled cycle lets the pipeline retire the ecall; the
            // flag still present here must not start a second service.
            DONE: begin
                ecall_done = 1'b1;
                state_d    = IDLE;
            end

            HALTED: begin
                stall_c    = 1'b1;
                Halt       = 1'b1;
                ecall_done = halt_entry_q;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The IDLE stall term follows ecall combinationally, so hold it low in reset.
    assign Stall       = Reset & stall_c;
    assign unknown_cnt = cnt_q;
    assign dbg_state   = state_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            code_q       <= '0;
            arg_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            halt_entry_q <= 1'b0;
        end else if (ClockEnable) begin
            state_q      <= state_d;
            code_q       <= code_d;
            arg_q        <= arg_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            halt_entry_q <= halt_entry_d;
        end
    end

endmodule

// File: tb/tb_ecall_responder.sv
// Directed self-checking bench for ecall_responder (default or ECALL_NEWLINE_EN build).
module tb_ecall_responder;
    import ecall_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ClockEnable;
    logic        ecall;
    logic [31:0] a7;
    logic [31:0] a0;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        Stall;
    logic        Halt;
    logic        ecall_done;
    logic [7:0]  unknown_cnt;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    ecall_responder #(.CNT_BITS(8)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ClockEnable (ClockEnable),
        .ecall       (ecall),
        .a7          (a7),
        .a0          (a0),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .Stall       (Stall),
        .Halt        (Halt),
        .ecall_done  (ecall_done),
        .unknown_cnt (unknown_cnt),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    always #5 Clock = ~Clock;

    // Monitor: capture transferred bytes and done pulses at mid-cycle.
    always @(negedge Clock) begin
        if (Reset && ClockEnable && out_valid && out_ready) obs_q.push_back(out_data);
        if (Reset && ClockEnable && ecall_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic start_ecall(input logic [31:0] code, input logic [31:0] arg);
        a7    = code;
        a0    = arg;
        ecall = 1'b1;
        #1;
    endtask

    task automatic push_hex(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                            input logic [7:0] b6, input logic [7:0] b7);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3);
        exp_q.push_back(b4); exp_q.push_back(b5); exp_q.push_back(b6); exp_q.push_back(b7);
`ifdef ECALL_NEWLINE_EN
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic sb_compare(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_byte"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        Reset       = 1'b0;
        ClockEnable = 1'b1;
        ecall       = 1'b1;
        a7          = 32'd1;
        a0          = 32'h1234ABCD;
        out_ready   = 1'b1;

        // Reset state (ecall high must not leak into Stall)
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_stall", Stall, 0);
        check("rst_halt", Halt, 0);
        check("rst_done", ecall_done, 0);
        check("rst_cnt", unknown_cnt, 0);
        check("rst_state", dbg_state, IDLE);
        ecall = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        tick();

        // PRINT_INT 1234ABCD, out_ready tied high
        done_cnt = 0;
        start_ecall(32'd1, 32'h1234ABCD);
        check("int_idle_stall", Stall, 1);
        check("int_idle_valid", out_valid, 0);
        push_hex(8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44);
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            check("int_stall", Stall, 1);
            check("int_valid", out_valid, 1);
            check("int_data", out_data, exp_q[i]);
        end
        tick();
        check("int_done_state", dbg_state, DONE);
        check("int_done_stall", Stall, 0);
        check("int_done_pulse", ecall_done, 1);
        check("int_done_valid", out_valid, 0);
        ecall = 1'b0;
        tick();
        check("int_after_done", ecall_done, 0);
        check("int_after_state", dbg_state, IDLE);
        sb_compare("int");
        check("int_done_cnt", done_cnt, 1);

        // PRINT_CHAR 'A' with out_ready 0,0,1
        done_cnt  = 0;
        out_ready = 1'b0;
        start_ecall(32'd11, 32'h00000041);
        check("chr_idle_stall", Stall, 1);
        exp_q.push_back(8'h41);
        tick();
        check("chr_valid1", out_valid, 1);
        check("chr_data1", out_data, 8'h41);
        tick();
        check("chr_valid2", out_valid, 1);
        check("chr_data2", out_data, 8'h41);
        out_ready = 1'b1;
        #1;
        check("chr_valid3", out_valid, 1);
        check("chr_data3", out_data, 8'h41);
        check("chr_stall3", Stall, 1);
        tick();
        check("chr_done_pulse", ecall_done, 1);
        check("chr_done_valid", out_valid, 0);
        ecall = 1'b0;
        tick();
        sb_compare("chr");
        check("chr_done_cnt", done_cnt, 1);

        // Unknown code 99 three times back-to-back, ecall held throughout
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            start_ecall(32'd99, 32'h0);
            check("unk_idle_state", dbg_state, IDLE);
            check("unk_idle_stall", Stall, 1);
            tick();
            check("unk_done_state", dbg_state, DONE);
            check("unk_done_pulse", ecall_done, 1);
            check("unk_done_stall", Stall, 0);
            check("unk_valid", out_valid, 0);
            check("unk_cnt", unknown_cnt, k + 1);
            if (k == 2) ecall = 1'b0;
            tick();
        end
        check("unk_final_cnt", unknown_cnt, 3);
        check("unk_final_state", dbg_state, IDLE);
        check("unk_done_cnt", done_cnt, 3);
        sb_compare("unk");

        // ClockEnable low for 5 cycles mid PRINT_INT DEADBEEF
        done_cnt = 0;
        start_ecall(32'd1, 32'hDEADBEEF);
        push_hex(8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46);
        tick();
        for (int i = 0; i < 2; i++) begin
            check("ce_pre_data", out_data, exp_q[i]);
            tick();
        end
        ClockEnable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ce_hold_valid", out_valid, 1);
            check("ce_hold_data", out_data, exp_q[2]);
            check("ce_hold_stall", Stall, 1);
        end
        ClockEnable = 1'b1;
        for (int i = 2; i < exp_q.size(); i++) begin
            check("ce_post_data", out_data, exp_q[i]);
            tick();
        end
        check("ce_done_pulse", ecall_done, 1);
        ecall = 1'b0;
        tick();
        sb_compare("ce");
        check("ce_done_cnt", done_cnt, 1);

        // Reset after 3 bytes of PRINT_INT A5000000, then restart from byte 0
        start_ecall(32'd1, 32'hA5000000);
        tick();
        tick(); tick(); tick();
        exp_q.push_back(8'h41); exp_q.push_back(8'h35); exp_q.push_back(8'h30);
        Reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_stall", Stall, 0);
        check("mid_rst_cnt", unknown_cnt, 0);
        check("mid_rst_state", dbg_state, IDLE);
        sb_compare("mid_rst");
        tick();
        Reset = 1'b1;
        #1;
        check("restart_stall", Stall, 1);
        done_cnt = 0;
        push_hex(8'h41, 8'h35, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30);
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            check("restart_data", out_data, exp_q[i]);
        end
        tick();
        check("restart_done", ecall_done, 1);
        ecall = 1'b0;
        tick();
        sb_compare("restart");
        check("restart_done_cnt", done_cnt, 1);

        // EXIT: absorbing halt with ecall held high
        done_cnt = 0;
        start_ecall(32'd10, 32'h0);
        check("halt_idle_halt", Halt, 0);
        check("halt_idle_stall", Stall, 1);
        tick();
        check("halt_entry_halt", Halt, 1);
        check("halt_entry_done", ecall_done, 1);
        check("halt_entry_valid", out_valid, 0);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("halt_hold_halt", Halt, 1);
            check("halt_hold_stall", Stall, 1);
            check("halt_hold_done", ecall_done, 0);
        end
        check("halt_done_cnt", done_cnt, 1);
        Reset = 1'b0;
        #1;
        check("halt_rst_halt", Halt, 0);
        check("halt_rst_stall", Stall, 0);
        ecall = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        check("halt_after_state", dbg_state, IDLE);
        check("halt_after_halt", Halt, 0);
        sb_compare("halt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
